// File: rtl/axi_ram_pkg.sv
// Shared encodings and helpers for the AXI-to-RAM controller.
// Burst and response codes follow the AXI encoding; state enums are private to each channel FSM.
package axi_ram_pkg;

  localparam int IDX_W  = 12;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  // FIXED holds the word; everything else steps linearly (WRAP is executed as INCR).
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       burst);
    return (burst == BURST_FIXED) ? idx : idx + 1'b1;
  endfunction

  // WRAP and the reserved code both map to an error response.
  function automatic logic burst_unsupported(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi_ram_rd.sv
// AXI read channel: one outstanding burst, one RAM lookup per beat into a registered rdata.
// state   | meaning
// R_IDLE  | arready high, waiting for an AR handshake
// R_FETCH | rd_addr presents the beat's index, rdata loads at the edge
// R_DATA  | rvalid high, beat held stable until rready
module axi_ram_rd
  import axi_ram_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic [11:0]       rd_addr,
  input  logic [63:0]       rd_data
);

  r_state_e         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_beat;
  logic [1:0]       r_burst;

  // Transfer size never changes the 8-byte step, and only bits [14:3] select a word.
  logic unused_ar;
  assign unused_ar = ^{arsize, araddr[ADDR_W-1:15], araddr[2:0]};

  assign rd_addr = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= BURST_FIXED;
      arready <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rid     <= arid;
            r_idx   <= araddr[14:3];
            r_len   <= arlen;
            r_burst <= arburst;
            r_beat  <= '0;
            rresp   <= burst_unsupported(arburst) ? RESP_SLVERR : RESP_OKAY;
            arready <= 1'b0;
            r_state <= R_FETCH;
          end else begin
            arready <= 1'b1;
          end
        end
        R_FETCH: begin
          rdata   <= rd_data;
          rlast   <= (r_beat == r_len);
          rvalid  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_idx   <= next_index(r_idx, r_burst);
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_ram_ctrl.sv
// AXI4 slave in front of a 4096 x 64-bit RAM; write channel here, read channel in axi_ram_rd.
// state  | meaning
// W_IDLE | awready high, waiting for an AW handshake
// W_DATA | wready high, each accepted beat writes the RAM in the same cycle
// W_RESP | bvalid high until bready
module axi_ram_ctrl
  import axi_ram_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              wr_en,
  output logic [11:0]       wr_addr,
  output logic [63:0]       wr_data,
  output logic [7:0]        wr_mask,
  output logic [11:0]       rd_addr,
  input  logic [63:0]       rd_data
);

  w_state_e         w_state;
  logic [ID_W-1:0]  w_id;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_beat;
  logic [1:0]       w_burst;
  logic             w_fire;
  logic             w_count_done;

  logic unused_aw;
  assign unused_aw = ^{awsize, awaddr[ADDR_W-1:15], awaddr[2:0]};

  assign w_fire       = wvalid & wready;
  assign w_count_done = (w_beat == w_len);

  // The RAM port is driven straight from the channel so a beat lands in its own cycle.
  assign wr_en   = w_fire & ~rst;
  assign wr_addr = w_idx;
  assign wr_data = wdata;
  assign wr_mask = wstrb;
  assign bid     = w_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= BURST_FIXED;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_id    <= awid;
            w_idx   <= awaddr[14:3];
            w_len   <= awlen;
            w_burst <= awburst;
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_beat <= w_beat + 8'd1;
            w_idx  <= next_index(w_idx, w_burst);
            // Whichever of wlast or the beat count comes first closes the burst.
            if (wlast || w_count_done) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (burst_unsupported(w_burst) || (wlast != w_count_done))
                         ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_ram_rd #(
    .ID_W   (ID_W),
    .ADDR_W (ADDR_W)
  ) u_rd (
    .clk     (clk),
    .rst     (rst),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// Bench for axi_ram_ctrl: behavioural RAM plus a word-array reference of expected contents.
module tb_axi_ram_ctrl;
  import axi_ram_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              wr_en;
  logic [11:0]       wr_addr;
  logic [63:0]       wr_data;
  logic [7:0]        wr_mask;
  logic [11:0]       rd_addr;
  logic [63:0]       rd_data;

  int n_checks = 0;
  int n_errors = 0;

  axi_ram_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] seed_word(input int i);
    logic [31:0] u;
    u = i;
    return {u * 32'h9E37_79B9, u ^ 32'hC3A5_0000};
  endfunction

  // Registered-write, combinational-read RAM attached to the DUT.
  logic [63:0] ram [0:4095];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= seed_word(i);
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++)
        if (wr_mask[b]) ram[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end
  assign rd_data = ram[rd_addr];

  logic [63:0] mem_ref [0:4095];

  function automatic int idx_of(input logic [31:0] a);
    return int'(a / 8) % 4096;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // All tasks start and end at a negedge.
  task automatic aw_handshake(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
    int guard = 0;
    while (!awready && guard < 50) begin cyc(); guard++; end
    chk("awready_wait", awready, 1'b1);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd3; awburst = burst; awvalid = 1'b1;
    cyc();
    awvalid = 1'b0;
  endtask

  task automatic ar_handshake(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
    int guard = 0;
    while (!arready && guard < 50) begin cyc(); guard++; end
    chk("arready_wait", arready, 1'b1);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'($urandom_range(0, 3));
    arburst = burst; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
  endtask

  // wlast_at: 1-based beat carrying wlast (beyond len+1 means never); strb 0 = random; d0 first-beat data (0 = random).
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int wlast_at,
                             input logic [7:0] strb, input logic [63:0] d0);
    int          idx, n_beats;
    logic [63:0] d;
    logic [7:0]  s;
    logic [1:0]  exp_resp;
    aw_handshake(id, addr, len, burst);
    idx     = idx_of(addr);
    n_beats = (wlast_at < len + 1) ? wlast_at : len + 1;
    for (int b = 1; b <= n_beats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        #1 chk("wr_en_gap", wr_en, 1'b0);
        cyc();
      end
      d = (b == 1 && d0 != 0) ? d0 : {$urandom, $urandom};
      s = (strb != 0) ? strb : 8'($urandom);
      wdata = d; wstrb = s; wlast = (b == wlast_at); wvalid = 1'b1;
      #1;
      chk("wr_en", wr_en, 1'b1);
      chk("wr_addr", wr_addr, 64'(idx));
      chk("wr_data", wr_data, d);
      chk("wr_mask", wr_mask, s);
      mem_ref[idx] = merge(mem_ref[idx], d, s);
      if (burst != BURST_FIXED) idx = (idx + 1) % 4096;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_resp = (burst[1] || ((wlast_at == n_beats) != (n_beats == len + 1))) ? RESP_SLVERR : RESP_OKAY;
    chk("bvalid", bvalid, 1'b1);
    chk("bid", bid, id);
    chk("bresp", bresp, exp_resp);
    chk("wready_resp", wready, 1'b0);
    repeat ($urandom_range(0, 2)) cyc();
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int max_stall);
    int         idx;
    logic [1:0] exp_resp;
    ar_handshake(id, addr, len, burst);
    idx      = idx_of(addr);
    exp_resp = burst[1] ? RESP_SLVERR : RESP_OKAY;
    for (int b = 0; b <= len; b++) begin
      chk("rvalid_fetch", rvalid, 1'b0);
      chk("rd_addr", rd_addr, 64'(idx));
      cyc();
      chk("rvalid", rvalid, 1'b1);
      chk("rdata", rdata, mem_ref[idx]);
      chk("rlast", rlast, b == len);
      chk("rid", rid, id);
      chk("rresp", rresp, exp_resp);
      repeat ($urandom_range(0, max_stall)) begin
        cyc();
        chk("rdata_hold", rdata, mem_ref[idx]);
        chk("rlast_hold", rlast, b == len);
      end
      rready = 1'b1;
      cyc();
      rready = 1'b0;
      if (burst != BURST_FIXED) idx = (idx + 1) % 4096;
    end
    chk("rvalid_end", rvalid, 1'b0);
    chk("arready_end", arready, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old_w, new_w;
    logic [31:0] a;
    int          l, la, xi;
    logic [1:0]  bu;

    rst = 1'b1; ram_init = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4096; i++) mem_ref[i] = seed_word(i);

    // Reset state
    cyc();
    ram_init = 1'b0;
    cyc();
    wvalid = 1'b1;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    @(negedge clk);
    wvalid = 1'b0;
    rst = 1'b0;
    chk("rel_awready_low", awready, 1'b0);
    cyc();
    chk("rel_awready", awready, 1'b1);
    chk("rel_arready", arready, 1'b1);

    // Single full-word write then readback
    write_burst(4'h5, 32'h10, 0, BURST_INCR, 1, 8'hFF, 64'h1122_3344_5566_7788);
    chk("single_word", mem_ref[2], 64'h1122_3344_5566_7788);
    read_burst(4'h5, 32'h10, 0, BURST_INCR, 2);

    // INCR read wrapping the index from 4095 to 0
    read_burst(4'h3, 32'h7FF8, 3, BURST_INCR, 1);

    // Partial write keeps the upper bytes
    write_burst(4'h1, 32'h2000, 0, BURST_INCR, 1, 8'h0F, 64'hAABB_CCDD_EEFF_0011);
    read_burst(4'h1, 32'h2000, 0, BURST_INCR, 0);

    // Early wlast, missing wlast, WRAP and FIXED bursts
    write_burst(4'h2, 32'h300, 3, BURST_INCR, 2, 8'h00, 64'd0);
    read_burst(4'h2, 32'h300, 3, BURST_INCR, 1);
    write_burst(4'h6, 32'h400, 1, BURST_INCR, 9, 8'h00, 64'd0);
    write_burst(4'h7, 32'h500, 2, BURST_WRAP, 3, 8'h00, 64'd0);
    read_burst(4'h7, 32'h500, 2, BURST_WRAP, 1);
    write_burst(4'h8, 32'h600, 3, BURST_FIXED, 4, 8'h00, 64'd0);
    read_burst(4'h8, 32'h600, 1, BURST_FIXED, 1);
    read_burst(4'h9, 32'h5F8, 2, 2'b11, 0);

    // Randomized bursts
    for (int k = 0; k < 12; k++) begin
      a  = $urandom;
      l  = $urandom_range(0, 7);
      bu = 2'($urandom_range(0, 3));
      la = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : l + 1;
      write_burst(4'($urandom), a, l, bu, la, 8'h00, 64'd0);
      read_burst(4'($urandom), a, $urandom_range(0, 7), 2'($urandom_range(0, 3)), 3);
    end

    // Same-cycle write/read to one word, then a long rready stall with another write
    xi = idx_of(32'd800);
    aw_handshake(4'hA, 32'd800, 0, BURST_INCR);
    ar_handshake(4'hB, 32'd800, 0, BURST_INCR);
    old_w = mem_ref[xi];
    new_w = {$urandom, $urandom};
    wdata = new_w; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    #1 chk("coll_wr_en", wr_en, 1'b1);
    mem_ref[xi] = new_w;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_pre_write", rdata, old_w);
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("stall_rdata1", rdata, old_w);
    aw_handshake(4'hA, 32'd800, 0, BURST_INCR);
    chk("stall_rdata2", rdata, old_w);
    new_w = {$urandom, $urandom};
    wdata = new_w; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    #1 chk("stall_wr_en", wr_en, 1'b1);
    mem_ref[xi] = new_w;
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    chk("stall_rdata3", rdata, old_w);
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    chk("stall_rdata4", rdata, old_w);
    chk("stall_rvalid", rvalid, 1'b1);
    cyc();
    chk("stall_rdata5", rdata, old_w);
    chk("stall_rlast", rlast, 1'b1);
    rready = 1'b1;
    cyc();
    rready = 1'b0;
    chk("stall_done", rvalid, 1'b0);
    read_burst(4'hB, 32'd800, 0, BURST_INCR, 0);

    // Reset in the middle of an 8-beat write and an 8-beat read
    rready = 1'b1;
    ar_handshake(4'hC, 32'h1000, 7, BURST_INCR);
    aw_handshake(4'hD, 32'h1800, 7, BURST_INCR);
    xi = idx_of(32'h1800);
    for (int b = 0; b < 3; b++) begin
      new_w = {$urandom, $urandom};
      wdata = new_w; wstrb = 8'hFF; wvalid = 1'b1;
      #1 chk("mid_wr_en", wr_en, 1'b1);
      mem_ref[(xi + b) % 4096] = new_w;
      @(negedge clk);
    end
    wdata = {$urandom, $urandom};
    rst = 1'b1;
    #1 chk("rst_cycle_wr_en", wr_en, 1'b0);
    @(negedge clk);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_wready", wready, 1'b0);
    chk("mid_rst_awready", awready, 1'b0);
    chk("mid_rst_rdata", rdata, 64'd0);
    chk("mid_rst_bid", bid, 0);
    rst = 1'b0; wvalid = 1'b0; rready = 1'b0;
    cyc();
    chk("mid_rel_awready", awready, 1'b1);
    chk("mid_rel_arready", arready, 1'b1);
    repeat (4) begin
      cyc();
      chk("mid_no_bvalid", bvalid, 1'b0);
      chk("mid_no_rvalid", rvalid, 1'b0);
    end
    read_burst(4'hE, 32'h1800, 7, BURST_INCR, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
